// File: rtl/pkt_dispatch.sv
// pkt_dispatch: routes upstream packets to one of CHN_NUM downstream channels.
// A single registered output stage (m_data/m_sel/m_sop/m_eop) is shared by all
// channels and feeds an external demux; m_valid is its one-hot channel valid.
// Packets addressed to a non-existent channel, and beats arriving outside a
// packet, are discarded and reported through err_pls / err_cnt.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   s_data/s_valid/s_sop/   upstream beat, framing and destination channel
//   s_eop/s_chn/s_ready     (s_chn sampled on the sop beat only)
//   m_data/m_sel/m_sop/     registered output beat and its channel
//   m_eop/m_valid/m_ready   one-hot valid, per-channel ready
//   err_pls/err_cnt         discard pulse, saturating discard count
module pkt_dispatch #(
  parameter int CHN_NUM = 6,
  parameter int DWID    = 256,
  parameter int NUMWID  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DWID-1:0]     s_data,
  input  logic                s_valid,
  input  logic                s_sop,
  input  logic                s_eop,
  input  logic [NUMWID-1:0]   s_chn,
  output logic                s_ready,
  output logic [DWID-1:0]     m_data,
  output logic [NUMWID-1:0]   m_sel,
  output logic [CHN_NUM-1:0]  m_valid,
  output logic                m_sop,
  output logic                m_eop,
  input  logic [CHN_NUM-1:0]  m_ready,
  output logic                err_pls,
  output logic [15:0]         err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [NUMWID:0] CHN_LIM = (NUMWID + 1)'(CHN_NUM);

  state_t            state, state_nxt;
  logic [NUMWID-1:0] cur_chn;
  logic [NUMWID-1:0] load_chn;
  logic              out_vld;
  logic              drain;
  logic              accept;
  logic              chn_ok;
  logic              load;
  logic              err_evt;

  always_comb begin
    m_valid = '0;
    for (int unsigned i = 0; i < CHN_NUM; i++) begin
      if (out_vld && (m_sel == NUMWID'(i))) m_valid[i] = 1'b1;
    end
  end

  // Only the selected channel's ready can drain the register, since m_valid
  // is one-hot on m_sel.
  assign drain   = |(m_valid & m_ready);
  assign s_ready = (state == DROP) | ~out_vld | drain;
  assign accept  = s_valid & s_ready;
  assign chn_ok  = {1'b0, s_chn} < CHN_LIM;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_chn  = cur_chn;
    err_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_sop) begin
            if (chn_ok) begin
              load      = 1'b1;
              load_chn  = s_chn;
              state_nxt = s_eop ? IDLE : BUSY;
            end else begin
              err_evt   = 1'b1;
              state_nxt = s_eop ? IDLE : DROP;
            end
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      BUSY: begin
        if (accept) begin
          load = 1'b1;
          if (s_eop) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (accept && s_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_chn <= '0;
      out_vld <= 1'b0;
      m_data  <= '0;
      m_sel   <= '0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
      err_pls <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cur_chn <= load_chn;
      // A load takes priority over a drain so that a simultaneous drain and
      // load keeps out_vld high without a bubble.
      if (load) begin
        out_vld <= 1'b1;
        m_data  <= s_data;
        m_sel   <= load_chn;
        m_sop   <= (state == IDLE);
        m_eop   <= s_eop;
      end else if (drain) begin
        out_vld <= 1'b0;
      end
      err_pls <= err_evt;
      if (err_evt && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pkt_dispatch.sv
module tb_pkt_dispatch;

  localparam int CHN_NUM = 6;
  localparam int DWID    = 256;
  localparam int NUMWID  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DWID-1:0]     s_data;
  logic                s_valid;
  logic                s_sop;
  logic                s_eop;
  logic [NUMWID-1:0]   s_chn;
  logic                s_ready;
  logic [DWID-1:0]     m_data;
  logic [NUMWID-1:0]   m_sel;
  logic [CHN_NUM-1:0]  m_valid;
  logic                m_sop;
  logic                m_eop;
  logic [CHN_NUM-1:0]  m_ready;
  logic                err_pls;
  logic [15:0]         err_cnt;

  always #5 clk = ~clk;

  pkt_dispatch #(
    .CHN_NUM(CHN_NUM),
    .DWID   (DWID),
    .NUMWID (NUMWID)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_sop  (s_sop),
    .s_eop  (s_eop),
    .s_chn  (s_chn),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_sel  (m_sel),
    .m_valid(m_valid),
    .m_sop  (m_sop),
    .m_eop  (m_eop),
    .m_ready(m_ready),
    .err_pls(err_pls),
    .err_cnt(err_cnt)
  );

  // Reference model: queue of beats the DUT owes downstream, packet mode,
  // expected error pulse and saturating error count.
  typedef struct {
    int              chn;
    logic [DWID-1:0] data;
    bit              sop;
    bit              eop;
  } beat_t;

  beat_t q[$];
  int    in_pkt;   // 0: between packets, 1: delivering, 2: discarding
  int    cur;
  bit    err_exp;
  int    cnt_m;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [DWID-1:0] obs, input logic [DWID-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_pkt  = 0;
    cur     = 0;
    err_exp = 1'b0;
    cnt_m   = 0;
  endtask

  // One clock: check outputs at negedge against the model, advance the model
  // with what the interface did on the coming posedge, return #1 after it.
  task automatic tick(output bit acc);
    beat_t              e;
    logic [CHN_NUM-1:0] ev;
    bit                 take;
    bit                 er;
    if (rand_rdy)
      for (int i = 0; i < CHN_NUM; i++) m_ready[i] = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    take = 1'b0;
    if (q.size() > 0) begin
      e = q[0];
      ev = '0;
      ev[e.chn] = 1'b1;
      chk("m_valid", m_valid, ev);
      chk("m_data", m_data, e.data);
      chk("m_sel", m_sel, e.chn);
      chk("m_sop", m_sop, e.sop);
      chk("m_eop", m_eop, e.eop);
      take = m_ready[e.chn];
    end else begin
      chk("m_valid_idle", m_valid, '0);
    end
    er = (in_pkt == 2) || (q.size() == 0) || take;
    chk("s_ready", s_ready, er);
    chk("err_pls", err_pls, err_exp);
    chk("err_cnt", err_cnt, cnt_m);
    acc = s_valid && er;
    if (!rst_n) begin
      model_reset();
      acc = 1'b0;
    end else begin
      if (take) void'(q.pop_front());
      err_exp = 1'b0;
      if (acc) begin
        case (in_pkt)
          0: begin
            if (s_sop) begin
              if (int'(s_chn) < CHN_NUM) begin
                q.push_back('{int'(s_chn), s_data, 1'b1, s_eop});
                cur    = int'(s_chn);
                in_pkt = s_eop ? 0 : 1;
              end else begin
                err_exp = 1'b1;
                in_pkt  = s_eop ? 0 : 2;
              end
            end else begin
              err_exp = 1'b1;
            end
          end
          1: begin
            q.push_back('{cur, s_data, 1'b0, s_eop});
            if (s_eop) in_pkt = 0;
          end
          default: if (s_eop) in_pkt = 0;
        endcase
        if (err_exp && cnt_m < 65535) cnt_m++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sop, input bit eop, input logic [NUMWID-1:0] chn);
    bit acc;
    int b;
    s_valid = 1'b1;
    s_sop   = sop;
    s_eop   = eop;
    s_chn   = chn;
    s_data  = {8{$urandom()}};
    acc = 1'b0;
    b   = 0;
    while (!acc && b < 200) begin
      tick(acc);
      b++;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed no accept expected accept within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic pkt(input logic [NUMWID-1:0] chn, input int len);
    for (int b = 0; b < len; b++)
      send(b == 0, b == len - 1, (b == 0) ? chn : NUMWID'($urandom_range(0, 7)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
    s_chn   = '0;
    s_data  = '0;
    m_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();

    // reset values
    chk("rst_m_valid", m_valid, '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_sel", m_sel, '0);
    chk("rst_m_sop", m_sop, 1'b0);
    chk("rst_m_eop", m_eop, 1'b0);
    chk("rst_err_pls", err_pls, 1'b0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    rst_n = 1'b1;
    chk("rst_s_ready", s_ready, 1'b1);

    // 4-beat packet to channel 2, all ready
    send(1'b1, 1'b0, 3'd2);
    chk("p1_first_valid", m_valid, 6'b000100);
    chk("p1_first_sop", m_sop, 1'b1);
    chk("p1_first_sel", m_sel, 3'd2);
    send(1'b0, 1'b0, 3'd5);
    send(1'b0, 1'b0, 3'd0);
    send(1'b0, 1'b1, 3'd7);
    chk("p1_last_valid", m_valid, 6'b000100);
    chk("p1_last_eop", m_eop, 1'b1);
    idle(2);

    // same packet with channel 2 stalled mid-packet, channel 0 ready toggling
    send(1'b1, 1'b0, 3'd2);
    send(1'b0, 1'b0, 3'd2);
    m_ready[2] = 1'b0;
    s_data = {8{$urandom()}};
    for (int k = 0; k < 3; k++) begin
      m_ready[0] = ~m_ready[0];
      tick(acc);
      chk("stall_s_ready", s_ready, 1'b0);
      chk("stall_m_valid", m_valid, 6'b000100);
    end
    m_ready = '1;
    send(1'b0, 1'b0, 3'd1);
    send(1'b0, 1'b1, 3'd1);
    idle(2);

    // single-beat packets back to back
    send(1'b1, 1'b1, 3'd0);
    chk("b2b_ch0", m_valid, 6'b000001);
    send(1'b1, 1'b1, 3'd5);
    chk("b2b_ch5", m_valid, 6'b100000);
    send(1'b1, 1'b1, 3'd3);
    chk("b2b_ch3", m_valid, 6'b001000);
    idle(2);

    // bad channel packet, then good packet to channel 1
    send(1'b1, 1'b0, 3'd7);
    chk("bad_err_pls", err_pls, 1'b1);
    chk("bad_no_valid", m_valid, '0);
    send(1'b0, 1'b0, 3'd1);
    chk("bad_single_pulse", err_pls, 1'b0);
    send(1'b0, 1'b1, 3'd1);
    pkt(3'd1, 3);
    chk("bad_err_cnt", err_cnt, 16'd1);
    idle(2);

    // stray beat outside a packet
    send(1'b0, 1'b0, 3'd0);
    chk("stray_err_pls", err_pls, 1'b1);
    chk("stray_err_cnt", err_cnt, 16'd2);
    idle(2);

    // reset during beat 2 of a delivering packet
    send(1'b1, 1'b0, 3'd4);
    s_sop  = 1'b0;
    s_data = {8{$urandom()}};
    rst_n  = 1'b0;
    tick(acc);
    rst_n  = 1'b1;
    s_valid = 1'b0;
    chk("midrst_m_valid", m_valid, '0);
    chk("midrst_m_data", m_data, '0);
    chk("midrst_err_cnt", err_cnt, 16'd0);
    chk("midrst_s_ready", s_ready, 1'b1);
    pkt(3'd3, 2);
    idle(2);

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) send(1'b0, $urandom_range(0, 1) == 1, 3'd0);
      pkt(NUMWID'($urandom_range(0, 7)), $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    m_ready = '1;
    idle(3);

    // error counter saturation
    s_valid = 1'b1;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
    for (int n = 0; n < 65540; n++) tick(acc);
    chk("sat_err_cnt", err_cnt, 16'hFFFF);
    chk("sat_err_pls", err_pls, 1'b1);
    idle(2);
    chk("sat_hold", err_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
